// File: rtl/apb_master_bridge_pkg.sv
// Shared types and default widths for the APB master bridge.
// The command struct is sized with the default widths.
package apb_master_bridge_pkg;

  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_ADDR_WIDTH     = 32;
  localparam int DEFAULT_NBYTES         = DEFAULT_DATA_WIDTH / 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  typedef struct packed {
    logic                          write;
    logic [DEFAULT_ADDR_WIDTH-1:0] addr;
    logic [DEFAULT_DATA_WIDTH-1:0] wdata;
    logic [DEFAULT_NBYTES-1:0]     strb;
  } apb_cmd_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Interface bundle for the bridge: command, response and APB bus signals.
// The master modport is the bridge's view; slave is the agent/APB-side view.
interface apb_master_bridge_if
  import apb_master_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
  localparam int NBYTES = DATA_WIDTH / 8;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [NBYTES-1:0]     cmd_strb;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_error;

  logic                  PSELx;
  logic                  PENABLE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PWRITE;
  logic [NBYTES-1:0]     PSTRB;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_error,
    input  rsp_ready,
    output PSELx, PENABLE, PADDR, PWRITE, PSTRB, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_error,
    output rsp_ready,
    input  PSELx, PENABLE, PADDR, PWRITE, PSTRB, PWDATA,
    output PRDATA, PREADY
  );

endinterface

// File: rtl/apb_master_bridge_wait_timer.sv
// Counts ACCESS cycles spent waiting for PREADY and flags the last allowed one.
// TIMEOUT_CYCLES of 0 means the timer never expires.
module apb_master_bridge_wait_timer
  import apb_master_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != '1)) begin
      r_count <= r_count + CW'(1);
    end
  end

  // Expiry is flagged while the final permitted wait cycle is in progress.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_limit
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
      assign o_expired = (r_count == LAST);
    end else begin : g_forever
      assign o_expired = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: takes one command over valid/ready, runs a SETUP+ACCESS
// transfer with a PREADY timeout, and returns data/status over valid/ready.
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic                 PCLK,
  input logic                 PRESET,
  apb_master_bridge_if.master bus
);

  localparam int NBYTES = DATA_WIDTH / 8;

  apb_state_e            r_state;
  apb_state_e            w_stateNext;
  logic                  w_accept;
  logic                  w_expired;
  logic                  w_timerEnable;

  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [NBYTES-1:0]     r_pstrb;
  logic                  r_rspValid;
  logic [DATA_WIDTH-1:0] r_rspRdata;
  logic                  r_rspError;

  assign w_accept      = (r_state == IDLE) && bus.cmd_valid;
  assign w_timerEnable = (r_state == ACCESS) && !bus.PREADY;

  apb_master_bridge_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_waitTimer (
    .i_clk    (PCLK),
    .i_rst    (PRESET),
    .i_clear  (w_accept),
    .i_enable (w_timerEnable),
    .o_expired(w_expired)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      IDLE:    if (bus.cmd_valid) w_stateNext = SETUP;
      SETUP:   w_stateNext = ACCESS;
      ACCESS:  if (bus.PREADY || w_expired) w_stateNext = RESP;
      RESP:    if (bus.rsp_ready) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Bus and response registers; PREADY takes priority over a same-cycle timeout.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_psel     <= 1'b0;
      r_penable  <= 1'b0;
      r_pwrite   <= 1'b0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
      r_pstrb    <= '0;
      r_rspValid <= 1'b0;
      r_rspRdata <= '0;
      r_rspError <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_psel   <= 1'b1;
            r_paddr  <= bus.cmd_addr;
            r_pwrite <= bus.cmd_write;
            r_pwdata <= bus.cmd_wdata;
            r_pstrb  <= bus.cmd_write ? bus.cmd_strb : '0;
          end
        end
        SETUP: r_penable <= 1'b1;
        ACCESS: begin
          if (bus.PREADY) begin
            r_rspRdata <= r_pwrite ? '0 : bus.PRDATA;
            r_rspError <= 1'b0;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_rspValid <= 1'b1;
          end else if (w_expired) begin
            r_rspRdata <= '0;
            r_rspError <= 1'b1;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_rspValid <= 1'b1;
          end
        end
        RESP: if (bus.rsp_ready) r_rspValid <= 1'b0;
        default: r_rspValid <= 1'b0;
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.PSELx     = r_psel;
  assign bus.PENABLE   = r_penable;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;
  assign bus.PSTRB     = r_pstrb;
  assign bus.rsp_valid = r_rspValid;
  assign bus.rsp_rdata = r_rspRdata;
  assign bus.rsp_error = r_rspError;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: a memory-backed APB slave model
// plus transaction-level expectations for timing, data and timeouts.
module tb_apb_master_bridge;
  import apb_master_bridge_pkg::*;

  localparam int TIMEOUT = 16;

  logic PCLK;
  logic PRESET;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] mem [logic [31:0]];

  apb_master_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  apb_master_bridge #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus.master)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] readModel(input logic [31:0] addr);
    return mem.exists(addr) ? mem[addr] : 32'h0;
  endfunction

  // Byte-strobed write into the slave memory model.
  task automatic writeModel(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] v;
    v = readModel(addr);
    for (int b = 0; b < 4; b++)
      if (strb[b]) v[8*b +: 8] = data[8*b +: 8];
    mem[addr] = v;
  endtask

  // One full transfer starting and ending on a falling edge with the bridge idle.
  // waits = ACCESS cycles with PREADY low before PREADY rises (>= TIMEOUT never rises).
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input int waits, input int rspDelay);
    logic [3:0]  expStrb;
    logic [31:0] expRdata;
    logic        expErr;
    int          acc;
    bit          done;
    expStrb  = wr ? strb : 4'h0;
    expRdata = 32'h0;
    expErr   = 1'b0;

    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_strb  = strb;
    checkOutput("idle_cmd_ready", bus.cmd_ready, 1);
    @(negedge PCLK);

    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
    bus.cmd_strb  = 4'($urandom);
    checkOutput("setup_psel", bus.PSELx, 1);
    checkOutput("setup_penable", bus.PENABLE, 0);
    checkOutput("setup_paddr", bus.PADDR, addr);
    checkOutput("setup_pwrite", bus.PWRITE, wr);
    checkOutput("setup_pwdata", bus.PWDATA, wdata);
    checkOutput("setup_pstrb", bus.PSTRB, expStrb);
    checkOutput("setup_cmd_ready", bus.cmd_ready, 0);
    @(negedge PCLK);

    acc  = 0;
    done = 0;
    while (!done) begin
      checkOutput("access_psel", bus.PSELx, 1);
      checkOutput("access_penable", bus.PENABLE, 1);
      checkOutput("access_paddr", bus.PADDR, addr);
      checkOutput("access_pwdata", bus.PWDATA, wdata);
      checkOutput("access_pstrb", bus.PSTRB, expStrb);
      checkOutput("access_rsp_valid", bus.rsp_valid, 0);
      if (acc == waits) begin
        bus.PREADY = 1'b1;
        bus.PRDATA = wr ? $urandom : readModel(addr);
        expRdata   = wr ? 32'h0 : readModel(addr);
        expErr     = 1'b0;
        done       = 1;
        if (wr) writeModel(addr, wdata, strb);
      end else begin
        bus.PREADY = 1'b0;
        bus.PRDATA = $urandom;
        if (acc == TIMEOUT - 1) begin
          expRdata = 32'h0;
          expErr   = 1'b1;
          done     = 1;
        end
      end
      acc++;
      @(negedge PCLK);
    end
    bus.PREADY = 1'b0;

    for (int d = 0; d <= rspDelay; d++) begin
      checkOutput("resp_valid", bus.rsp_valid, 1);
      checkOutput("resp_rdata", bus.rsp_rdata, expRdata);
      checkOutput("resp_error", bus.rsp_error, expErr);
      checkOutput("resp_cmd_ready", bus.cmd_ready, 0);
      checkOutput("resp_psel", bus.PSELx, 0);
      checkOutput("resp_penable", bus.PENABLE, 0);
      if (d == rspDelay) begin
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b0;
      end else begin
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'($urandom_range(0, 1));
      end
      @(negedge PCLK);
    end
    bus.rsp_ready = 1'b0;
    checkOutput("done_rsp_valid", bus.rsp_valid, 0);
    checkOutput("done_cmd_ready", bus.cmd_ready, 1);
    checkOutput("done_psel", bus.PSELx, 0);
  endtask

  // Starts a read, then pulses reset in its first ACCESS cycle.
  task automatic applyResetMidTransfer(input logic [31:0] addr);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = addr;
    bus.cmd_strb  = 4'hF;
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    @(negedge PCLK);
    checkOutput("rst_mid_penable_before", bus.PENABLE, 1);
    bus.PREADY = 1'b0;
    #2;
    PRESET = 1'b1;
    #1;
    checkOutput("rst_mid_psel", bus.PSELx, 0);
    checkOutput("rst_mid_penable", bus.PENABLE, 0);
    checkOutput("rst_mid_rsp_valid", bus.rsp_valid, 0);
    checkOutput("rst_mid_paddr", bus.PADDR, 0);
    @(negedge PCLK);
    PRESET = 1'b0;
    checkOutput("rst_mid_cmd_ready", bus.cmd_ready, 1);
    @(negedge PCLK);
    checkOutput("rst_mid_stays_idle", bus.PSELx, 0);
  endtask

  initial begin
    logic        wr;
    logic [31:0] addr;
    int          waits;
    int          pick;

    PRESET        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;

    repeat (2) @(negedge PCLK);
    checkOutput("reset_psel", bus.PSELx, 0);
    checkOutput("reset_penable", bus.PENABLE, 0);
    checkOutput("reset_pwrite", bus.PWRITE, 0);
    checkOutput("reset_paddr", bus.PADDR, 0);
    checkOutput("reset_pstrb", bus.PSTRB, 0);
    checkOutput("reset_pwdata", bus.PWDATA, 0);
    checkOutput("reset_rsp_valid", bus.rsp_valid, 0);
    checkOutput("reset_rsp_error", bus.rsp_error, 0);
    checkOutput("reset_rsp_rdata", bus.rsp_rdata, 0);
    checkOutput("reset_cmd_ready", bus.cmd_ready, 1);
    PRESET = 1'b0;
    @(negedge PCLK);
    checkOutput("post_reset_cmd_ready", bus.cmd_ready, 1);

    applyStimulus(1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF, 0, 0);
    applyStimulus(1'b0, 32'h4, 32'h0, 4'hF, 0, 0);
    checkOutput("readback_deadbeef", readModel(32'h4), 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h4, 32'h1234_5678, 4'h5, 3, 0);
    applyStimulus(1'b0, 32'h8, 32'h0, 4'h0, 100, 0);
    applyStimulus(1'b0, 32'h4, 32'h0, 4'h0, TIMEOUT - 1, 0);
    applyStimulus(1'b1, 32'h4, 32'hAABB_CCDD, 4'h6, 1, 5);
    applyStimulus(1'b0, 32'h4, 32'h0, 4'h0, 0, 5);
    applyStimulus(1'b1, 32'hC, 32'h5555_AAAA, 4'hF, 100, 2);
    applyStimulus(1'b0, 32'hC, 32'h0, 4'hF, 2, 1);

    applyResetMidTransfer(32'h4);
    applyStimulus(1'b0, 32'h4, 32'h0, 4'h0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 7)) * 32'd4;
      pick = $urandom_range(0, 9);
      if (pick < 6)      waits = $urandom_range(0, 3);
      else if (pick < 8) waits = TIMEOUT - 1;
      else               waits = $urandom_range(TIMEOUT, TIMEOUT + 4);
      applyStimulus(wr, addr, $urandom, 4'($urandom), waits, $urandom_range(0, 4));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
